ddr_wr_arbiter: RTL and testbench
=================================

Name: ddr_wr_arbiter

Overview:
- Round-robin arbiter that shares the single DDR AXI4 write-side interface among NUM_CH write requesters (video capture, encoder output, etc.).
- Sits between the requesters and the AXI4 write master interface.
- Drives that interface's request, address, burst-size and data inputs.
- Returns per-channel acknowledge and done pulses.
- Holds one grant from request until done; there is no preemption.

Parameters:
- NUM_CH, 4, number of write requesters (legal range 2..8).
- AXI_DATA_WIDTH, 64, write data width.
- AXI_ADDR_WIDTH, 32, write address width.
- WDOG_CYCLES, 4096, data-phase timeout in clocks; used only with the optional feature.

Ports:
- SYS_CLK_I  in  1  system clock; all logic is on the rising edge.
- RESET_I  in  1  asynchronous, active-high reset.
- CH_REQ_I  in  NUM_CH  per-channel write request; level, held until the channel's CH_ACK_O.
- CH_START_ADDR_I  in  NUM_CH*AXI_ADDR_WIDTH  flattened start addresses; channel k occupies bits [k*W +: W].
- CH_BURST_SIZE_I  in  NUM_CH*8  flattened burst sizes.
- CH_DATA_I  in  NUM_CH*AXI_DATA_WIDTH  flattened write data.
- CH_DATA_VALID_I  in  NUM_CH  per-channel data valid.
- CH_ACK_O  out  NUM_CH  one-cycle pulse: channel's request accepted by the AXI interface.
- CH_DONE_O  out  NUM_CH  one-cycle pulse: channel's burst finished.
- CH_GRANT_O  out  NUM_CH  one-hot, or zero when idle; current owner.
- W_REQ_O  out  1  write request to the AXI interface.
- W_START_ADDR_O  out  AXI_ADDR_WIDTH  registered start address.
- W_BURST_SIZE_O  out  8  registered burst size.
- W_DATA_O  out  AXI_DATA_WIDTH  data of the granted channel.
- W_DATA_VALID_O  out  1  valid of the granted channel, gated by the DATA state.
- W_ACK_I  in  1  AXI interface accepted the request.
- W_DONE_I  in  1  AXI interface write response received (burst complete).
- WDOG_ERR_O  out  1  sticky data-phase timeout flag.

Behaviour:
- Reset: state IDLE, round-robin pointer 0, all outputs 0.
- States: IDLE, REQ, DATA, DONE.
- IDLE:
  - If any CH_REQ_I is set, pick the first set bit searching upward from the pointer, wrapping at NUM_CH-1 to 0.
  - Register CH_GRANT_O, W_START_ADDR_O and W_BURST_SIZE_O from that channel.
  - Set W_REQ_O=1 and go to REQ.
  - Latency: request seen in cycle N gives W_REQ_O=1 in cycle N+1.
- REQ:
  - Hold W_REQ_O, address and burst size stable until W_ACK_I=1.
  - On W_ACK_I: W_REQ_O=0 and CH_ACK_O[grant]=1 on the next cycle; go to DATA.
- DATA:
  - W_DATA_O and W_DATA_VALID_O are a combinational mux of the granted channel; no added latency.
  - On W_DONE_I: go to DONE.
- DONE:
  - Pulse CH_DONE_O[grant] for one cycle.
  - Clear CH_GRANT_O.
  - Pointer = (grant+1) mod NUM_CH.
  - Return to IDLE. A new grant cannot be issued in this cycle, so the minimum turnaround is 2 cycles from done to the next W_REQ_O.
- W_DATA_VALID_O is 0 in IDLE, REQ and DONE, whatever the CH_DATA_VALID_I values.
- W_DATA_O in those states is don't-care.
- Simultaneous W_ACK_I and W_DONE_I in REQ: CH_ACK_O and CH_DONE_O both pulse on the next cycle; go directly to DONE handling, then IDLE.
- W_ACK_I outside REQ is ignored. W_DONE_I outside DATA/REQ is ignored.
- A channel dropping CH_REQ_I after grant does not cancel the transaction; the arbiter completes it.
- Non-granted channels' CH_DATA_VALID_I are ignored.
- Only one grant is outstanding at a time.
- Reset asserted mid-burst: everything returns to reset values immediately (asynchronous). Any partial AXI transaction is the AXI interface's concern.
- Pointer arithmetic uses ceil(log2(NUM_CH)) bits with explicit wrap, so NUM_CH need not be a power of 2.

Optional Feature:
- Macro: DDR_WR_ARB_WDOG_EN.
- Defined:
  - A counter clears on entry to REQ and counts every cycle in REQ or DATA.
  - If it reaches WDOG_CYCLES, WDOG_ERR_O is set and held until reset.
  - Arbitration is not aborted.
- Undefined: no counter; WDOG_ERR_O tied to 0.

Test Plan:
- Single channel: CH_REQ_I=0001, addr 0x1000_0000, size 0x10, W_ACK_I 3 cycles later, W_DONE_I 20 cycles later -> W_REQ_O high cycles 1–3, CH_ACK_O[0] pulse, data passthrough, CH_DONE_O[0] pulse, grant 0.
- All four requesting continuously -> grant order 0,1,2,3,0; each CH_DONE_O pulses once per burst; W_START_ADDR_O matches the owner each time.
- Pointer at 3 with only CH_REQ_I=0010 -> wraps, grants channel 1.
- W_ACK_I and W_DONE_I asserted in the same cycle in REQ -> CH_ACK_O[k] and CH_DONE_O[k] pulse together; IDLE two cycles later.
- RESET_I pulsed during DATA -> all outputs 0 asynchronously, pointer 0; the next request from channel 2 is granted normally.
- With DDR_WR_ARB_WDOG_EN, WDOG_CYCLES=64, W_DONE_I withheld -> WDOG_ERR_O=1 at cycle 64 after entering REQ, and stays 1 after a later W_DONE_I.

Source files
------------

// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter sharing one DDR AXI4 write-side interface among NUM_CH requesters.
// Optional data-phase watchdog: define DDR_WR_ARB_WDOG_EN (otherwise WDOG_ERR_O is tied to 0).
module ddr_wr_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int WDOG_CYCLES    = 4096
) (
  input  logic                               SYS_CLK_I,
  input  logic                               RESET_I,
  input  logic [NUM_CH-1:0]                  CH_REQ_I,
  input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0]   CH_START_ADDR_I,
  input  logic [NUM_CH*8-1:0]                CH_BURST_SIZE_I,
  input  logic [NUM_CH*AXI_DATA_WIDTH-1:0]   CH_DATA_I,
  input  logic [NUM_CH-1:0]                  CH_DATA_VALID_I,
  output logic [NUM_CH-1:0]                  CH_ACK_O,
  output logic [NUM_CH-1:0]                  CH_DONE_O,
  output logic [NUM_CH-1:0]                  CH_GRANT_O,
  output logic                               W_REQ_O,
  output logic [AXI_ADDR_WIDTH-1:0]          W_START_ADDR_O,
  output logic [7:0]                         W_BURST_SIZE_O,
  output logic [AXI_DATA_WIDTH-1:0]          W_DATA_O,
  output logic                               W_DATA_VALID_O,
  input  logic                               W_ACK_I,
  input  logic                               W_DONE_I,
  output logic                               WDOG_ERR_O
);

  localparam int PTR_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 8 || WDOG_CYCLES < 1) begin : g_param_check
    $error("ddr_wr_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA, ST_DONE} state_t;

  state_t                    r_state;
  logic [PTR_W-1:0]          r_ptr;
  logic [PTR_W-1:0]          r_grant_idx;
  logic [NUM_CH-1:0]         r_grant;
  logic [NUM_CH-1:0]         r_ack;
  logic [NUM_CH-1:0]         r_done;
  logic                      r_w_req;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_size;

  logic [AXI_ADDR_WIDTH-1:0] w_ch_addr [NUM_CH];
  logic [7:0]                w_ch_size [NUM_CH];
  logic [AXI_DATA_WIDTH-1:0] w_ch_data [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign w_ch_addr[k] = CH_START_ADDR_I[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign w_ch_size[k] = CH_BURST_SIZE_I[k*8 +: 8];
    assign w_ch_data[k] = CH_DATA_I[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

  // Search upward from the pointer with an explicit wrap, so NUM_CH need not be a power of 2.
  logic             w_found;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W:0]   w_cand;

  always_comb begin
    // NOTE: every signal written here gets a default first; a missed path would infer a latch.
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cand = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_cand >= (PTR_W+1)'(NUM_CH)) w_cand = w_cand - (PTR_W+1)'(NUM_CH);
      if (!w_found && CH_REQ_I[w_cand[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
    if (RESET_I) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant_idx <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_done      <= '0;
      r_w_req     <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples the pre-edge values.
      r_ack  <= '0;
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_idx <= w_pick;
            r_grant     <= NUM_CH'(1) << w_pick;
            r_addr      <= w_ch_addr[w_pick];
            r_size      <= w_ch_size[w_pick];
            r_w_req     <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (W_ACK_I) begin
            r_w_req <= 1'b0;
            r_ack   <= r_grant;
            // A response arriving with the accept closes the burst straight away.
            if (W_DONE_I) begin
              r_done  <= r_grant;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (W_DONE_I) begin
            r_done  <= r_grant;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_grant <= '0;
          r_ptr   <= (r_grant_idx == PTR_W'(NUM_CH-1)) ? '0 : r_grant_idx + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign CH_ACK_O       = r_ack;
  assign CH_DONE_O      = r_done;
  assign CH_GRANT_O     = r_grant;
  assign W_REQ_O        = r_w_req;
  assign W_START_ADDR_O = r_addr;
  assign W_BURST_SIZE_O = r_size;
  assign W_DATA_O       = (r_state == ST_DATA) ? w_ch_data[r_grant_idx] : '0;
  assign W_DATA_VALID_O = (r_state == ST_DATA) && CH_DATA_VALID_I[r_grant_idx];

`ifdef DDR_WR_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wdog_cnt;
  logic            r_wdog_err;

  // Counter saturates at WDOG_CYCLES; the flag stays set until reset.
  always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
    if (RESET_I) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else if (r_state == ST_IDLE && w_found) begin
      r_wdog_cnt <= '0;
    end else if ((r_state == ST_REQ || r_state == ST_DATA) &&
                 r_wdog_cnt != WD_W'(WDOG_CYCLES)) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
      if (r_wdog_cnt == WD_W'(WDOG_CYCLES - 1)) r_wdog_err <= 1'b1;
    end
  end

  assign WDOG_ERR_O = r_wdog_err;
`else
  assign WDOG_ERR_O = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Self-checking bench for ddr_wr_arbiter: directed scenarios plus randomized bursts
// checked against a transaction-level round-robin model.
module tb_ddr_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [AW-1:0]   m_addr  [N];
  logic [7:0]      m_size  [N];
  logic [DW-1:0]   m_data  [N];
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] ch_addr;
  logic [N*8-1:0]  ch_size;
  logic [N*DW-1:0] ch_data;
  logic            w_ack_i;
  logic            w_done_i;

  logic [N-1:0]    ch_ack, ch_done, ch_grant;
  logic            w_req, w_valid, wdog_err;
  logic [AW-1:0]   w_addr;
  logic [7:0]      w_size;
  logic [DW-1:0]   w_data;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr      = 0;   // model round-robin pointer

  always #5 clk = ~clk;

  always_comb begin
    ch_addr = '0;
    ch_size = '0;
    ch_data = '0;
    for (int c = 0; c < N; c++) begin
      ch_addr[c*AW +: AW] = m_addr[c];
      ch_size[c*8 +: 8]   = m_size[c];
      ch_data[c*DW +: DW] = m_data[c];
    end
  end

  ddr_wr_arbiter #(
    .NUM_CH(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .WDOG_CYCLES(64)
  ) dut (
    .SYS_CLK_I(clk),            .RESET_I(rst),
    .CH_REQ_I(req),             .CH_START_ADDR_I(ch_addr),
    .CH_BURST_SIZE_I(ch_size),  .CH_DATA_I(ch_data),
    .CH_DATA_VALID_I(m_valid),  .CH_ACK_O(ch_ack),
    .CH_DONE_O(ch_done),        .CH_GRANT_O(ch_grant),
    .W_REQ_O(w_req),            .W_START_ADDR_O(w_addr),
    .W_BURST_SIZE_O(w_size),    .W_DATA_O(w_data),
    .W_DATA_VALID_O(w_valid),   .W_ACK_I(w_ack_i),
    .W_DONE_I(w_done_i),        .WDOG_ERR_O(wdog_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Reference: first requesting channel at or after the pointer, wrapping around.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Runs one whole burst starting from IDLE with req already driven; ends in IDLE.
  task automatic do_burst(input int d_ack, input bit both, input int d_data,
                          input bit keep_req, output logic [N-1:0] g_obs);
    int            k;
    logic [N-1:0]  exp_oh;
    logic [AW-1:0] exp_addr;
    k        = rr_pick(req, ptr);
    exp_oh   = oh(k);
    exp_addr = m_addr[k];
    m_valid  = '1;
    tick();
    g_obs = ch_grant;
    check("w_req_rise", w_req, 1);
    check("grant", ch_grant, exp_oh);
    check("start_addr", w_addr, exp_addr);
    check("burst_size", w_size, m_size[k]);
    check("valid_gate_req", w_valid, 0);
    for (int i = 0; i < d_ack; i++) begin
      m_addr[k] = $urandom;
      tick();
      check("w_req_hold", w_req, 1);
      check("addr_hold", w_addr, exp_addr);
      check("no_early_ack", ch_ack, 0);
    end
    w_ack_i  = 1'b1;
    w_done_i = both;
    tick();
    w_ack_i  = 1'b0;
    w_done_i = 1'b0;
    if (!keep_req) req[k] = 1'b0;
    check("ack_pulse", ch_ack, exp_oh);
    check("w_req_drop", w_req, 0);
    if (!both) begin
      check("no_early_done", ch_done, 0);
      for (int i = 0; i <= d_data; i++) begin
        for (int c = 0; c < N; c++) m_data[c] = {$urandom, $urandom};
        m_valid  = N'($urandom);
        w_ack_i  = ($urandom_range(0, 3) == 0);
        w_done_i = (i == d_data);
        #1;
        check("data_mux", w_data, m_data[k]);
        check("valid_mux", w_valid, m_valid[k]);
        tick();
        check("stray_ack_ignored", ch_ack, 0);
      end
      w_ack_i  = 1'b0;
      w_done_i = 1'b0;
    end
    m_valid = '1;
    #1;
    check("done_pulse", ch_done, exp_oh);
    check("valid_gate_done", w_valid, 0);
    ptr = (k + 1) % N;
    tick();
    check("idle_grant", ch_grant, 0);
    check("idle_done", ch_done, 0);
    check("idle_w_req", w_req, 0);
    check("valid_gate_idle", w_valid, 0);
    check("wdog_quiet", wdog_err, 0);
  endtask

  initial begin
    logic [N-1:0] g;
    int order [5] = '{0, 1, 2, 3, 0};
    rst      = 1'b1;
    req      = '0;
    m_valid  = '0;
    w_ack_i  = 1'b0;
    w_done_i = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_addr[c] = 32'h1000_0000 * (c + 1);
      m_size[c] = 8'(c + 1);
      m_data[c] = {$urandom, $urandom};
    end
    tick();
    tick();
    check("rst_w_req", w_req, 0);
    check("rst_grant", ch_grant, 0);
    check("rst_ack_done", {ch_ack, ch_done}, 0);
    check("rst_addr_size", {w_addr, w_size}, 0);
    rst = 1'b0;
    tick();

    // All channels requesting continuously: strict rotation from pointer 0.
    req = '1;
    for (int i = 0; i < 5; i++) begin
      do_burst(1, 1'b0, 2, 1'b1, g);
      check("rr_order", g, oh(order[i]));
    end
    req = '0;

    // Single channel, accept 3 cycles after the request, response 20 cycles after accept.
    m_addr[0] = 32'h1000_0000;
    m_size[0] = 8'h10;
    req       = 4'b0001;
    do_burst(2, 1'b0, 19, 1'b0, g);

    // Grant channel 2 so the pointer sits at 3, then only channel 1 asks: must wrap.
    req = 4'b0100;
    do_burst(0, 1'b0, 1, 1'b0, g);
    req = 4'b0010;
    do_burst(1, 1'b0, 1, 1'b0, g);
    check("wrap_grant", g, 4'b0010);

    // Accept and response in the same cycle.
    req = 4'b1001;
    do_burst(1, 1'b1, 0, 1'b0, g);
    req = '0;

    // Asynchronous reset in the middle of a data phase.
    req = 4'b0001;
    tick();
    check("pre_rst_w_req", w_req, 1);
    w_ack_i = 1'b1;
    tick();
    w_ack_i   = 1'b0;
    req       = '0;
    m_valid   = '1;
    m_data[0] = 64'hDEAD_BEEF_0123_4567;
    #1;
    check("pre_rst_valid", w_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_grant", ch_grant, 0);
    check("async_rst_valid", w_valid, 0);
    check("async_rst_data", w_data, 0);
    check("async_rst_outs", {w_req, ch_ack, ch_done, w_addr, w_size}, 0);
    tick();
    rst = 1'b0;
    ptr = 0;
    tick();
    req = 4'b0100;
    do_burst(1, 1'b0, 2, 1'b0, g);
    check("post_rst_grant", g, 4'b0100);

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < N; c++) begin
        if (!req[c] && $urandom_range(0, 2) == 0) begin
          m_addr[c] = $urandom;
          m_size[c] = 8'($urandom_range(0, 255));
          req[c]    = 1'b1;
        end
      end
      if (req == '0) begin
        tick();
        check("idle_no_req", w_req, 0);
      end else begin
        do_burst($urandom_range(0, 4), ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 6), 1'b0, g);
      end
    end
    for (int i = 0; i < N && req != '0; i++) do_burst(0, 1'b0, 1, 1'b0, g);

`ifdef DDR_WR_ARB_WDOG_EN
    // Response withheld: flag rises on the 64th REQ/DATA cycle edge and sticks.
    req = 4'b0001;
    tick();
    w_ack_i = 1'b1;
    tick();
    w_ack_i = 1'b0;
    req     = '0;
    repeat (62) tick();
    check("wdog_before_limit", wdog_err, 0);
    tick();
    check("wdog_fire", wdog_err, 1);
    w_done_i = 1'b1;
    tick();
    w_done_i = 1'b0;
    tick();
    tick();
    check("wdog_sticky", wdog_err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
